// File: rtl/ipml_prefetch_sfifo_v2_0.sv
// Single-clock first-word-fall-through FIFO: a registered-read storage array
// feeding a 2-entry output skid stage, with level, almost flags and flush.
module ipml_prefetch_sfifo_v2_0 #(
    parameter int W        = 32,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2,
    localparam int LW      = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic [W-1:0]  data_in,
    input  logic          data_in_valid,
    output logic          data_in_ready,
    output logic [W-1:0]  data_out,
    output logic          data_out_valid,
    input  logic          data_out_ready,
    output logic [LW-1:0] level,
    output logic          almost_full,
    output logic          almost_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
    localparam logic [LW-1:0] AF_L     = LW'(AF_LEVEL);
    localparam logic [LW-1:0] AE_L     = LW'(AE_LEVEL);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [W-1:0]  mem [DEPTH];

    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [LW-1:0] arrCount_q, arrCount_d;
    logic [LW-1:0] level_q, level_d;
    logic          rdValid_q, rdValid_d;
    logic [W-1:0]  rdData_q;
    logic [1:0]    outCount_q, outCount_d;
    logic [W-1:0]  slot0_q, slot0_d;
    logic [W-1:0]  slot1_q, slot1_d;
    logic          inReady_q;
    logic          almostFull_q;
    logic          almostEmpty_q;

    logic          push;
    logic          pop;
    logic          land;
    logic          rdIssue;
    logic [1:0]    stageUsed;

    function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign push      = data_in_valid & inReady_q;
    assign pop       = (outCount_q != 2'd0) & data_out_ready;
    assign land      = rdValid_q;
    assign stageUsed = outCount_q + {1'b0, rdValid_q};

    // A read may issue into a full stage when a pop frees a slot this cycle,
    // which is what keeps streaming at one word per cycle.
    assign rdIssue = (arrCount_q != '0) & ((stageUsed != 2'd2) | pop);

    always_comb begin
        wrPtr_d    = push ? ptrInc(wrPtr_q) : wrPtr_q;
        rdPtr_d    = rdIssue ? ptrInc(rdPtr_q) : rdPtr_q;
        arrCount_d = arrCount_q + LW'(push) - LW'(rdIssue);
        level_d    = level_q + LW'(push) - LW'(pop);
        rdValid_d  = rdIssue;
        slot0_d    = slot0_q;
        slot1_d    = slot1_q;
        outCount_d = outCount_q;

        unique case ({land, pop})
            2'b01: begin
                slot0_d    = slot1_q;
                outCount_d = outCount_q - 2'd1;
            end
            2'b10: begin
                if (outCount_q == 2'd0) begin
                    slot0_d = rdData_q;
                end else begin
                    slot1_d = rdData_q;
                end
                outCount_d = outCount_q + 2'd1;
            end
            2'b11: begin
                if (outCount_q == 2'd1) begin
                    slot0_d = rdData_q;
                end else begin
                    slot0_d = slot1_q;
                    slot1_d = rdData_q;
                end
            end
            default: begin
            end
        endcase

        if (flush) begin
            wrPtr_d    = '0;
            rdPtr_d    = '0;
            arrCount_d = '0;
            level_d    = '0;
            rdValid_d  = 1'b0;
            outCount_d = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
            arrCount_q    <= '0;
            level_q       <= '0;
            rdValid_q     <= 1'b0;
            outCount_q    <= 2'd0;
            slot0_q       <= '0;
            slot1_q       <= '0;
            inReady_q     <= 1'b0;
            almostFull_q  <= 1'b0;
            almostEmpty_q <= 1'b1;
        end else begin
            wrPtr_q       <= wrPtr_d;
            rdPtr_q       <= rdPtr_d;
            arrCount_q    <= arrCount_d;
            level_q       <= level_d;
            rdValid_q     <= rdValid_d;
            outCount_q    <= outCount_d;
            slot0_q       <= slot0_d;
            slot1_q       <= slot1_d;
            inReady_q     <= (level_d != DEPTH_L);
            almostFull_q  <= (level_d >= AF_L);
            almostEmpty_q <= (level_d <= AE_L);
        end
    end

    // Storage is not reset; pointers and counts alone define its valid content.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wrPtr_q] <= data_in;
        end
        if (rdIssue) begin
            rdData_q <= mem[rdPtr_q];
        end
    end

    assign data_in_ready  = inReady_q;
    assign data_out       = slot0_q;
    assign data_out_valid = (outCount_q != 2'd0);
    assign level          = level_q;
    assign almost_full    = almostFull_q;
    assign almost_empty   = almostEmpty_q;

endmodule

// File: tb/tb_ipml_prefetch_sfifo_v2_0.sv
// Directed bench for ipml_prefetch_sfifo_v2_0: a DEPTH=16 instance for the main
// sequence and a DEPTH=5 instance for pointer wrap-around.
module tb_ipml_prefetch_sfifo_v2_0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        flush = 1'b0;
    logic [31:0] din = '0;
    logic        dinValid = 1'b0;
    logic        dinReady;
    logic [31:0] dout;
    logic        doutValid;
    logic        doutReady = 1'b0;
    logic [4:0]  level;
    logic        af;
    logic        ae;

    logic [31:0] din5 = '0;
    logic        dinValid5 = 1'b0;
    logic        dinReady5;
    logic [31:0] dout5;
    logic        doutValid5;
    logic        doutReady5 = 1'b0;
    logic [2:0]  level5;
    logic        af5;
    logic        ae5;

    int checks = 0;
    int failures = 0;

    ipml_prefetch_sfifo_v2_0 #(.W(32), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .data_in(din), .data_in_valid(dinValid), .data_in_ready(dinReady),
        .data_out(dout), .data_out_valid(doutValid), .data_out_ready(doutReady),
        .level(level), .almost_full(af), .almost_empty(ae)
    );

    ipml_prefetch_sfifo_v2_0 #(.W(32), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) dut5 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .data_in(din5), .data_in_valid(dinValid5), .data_in_ready(dinReady5),
        .data_out(dout5), .data_out_valid(doutValid5), .data_out_ready(doutReady5),
        .level(level5), .almost_full(af5), .almost_empty(ae5)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic r, input logic f);
        dinValid  = v;
        din       = d;
        doutReady = r;
        flush     = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitEmpty();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 100 && level != 5'd0; i++) tick();
        checkOutput("drainLevel", 32'(level), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    int          sent;
    int          rcv;
    int          pops;
    int          tp;
    logic        prevStall;
    logic [31:0] prevData;
    logic        seen;

    initial begin
        // Reset values while rst_n is low
        #12;
        checkBit("rstReady", dinReady, 1'b0);
        checkBit("rstValid", doutValid, 1'b0);
        checkOutput("rstData", dout, 32'h0);
        checkOutput("rstLevel", 32'(level), 32'd0);
        checkBit("rstAf", af, 1'b0);
        checkBit("rstAe", ae, 1'b1);
        checkBit("rstReady5", dinReady5, 1'b0);
        rst_n = 1'b1;
        tick();
        checkBit("readyAfterReset", dinReady, 1'b1);

        // First-word latency: push at edge 1, visible after edge 3
        applyStimulus(1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("lat1Level", 32'(level), 32'd1);
        checkBit("lat1Valid", doutValid, 1'b0);
        tick();
        checkBit("lat2Valid", doutValid, 1'b0);
        tick();
        checkBit("lat3Valid", doutValid, 1'b1);
        checkOutput("lat3Data", dout, 32'hA5A5_0001);
        checkOutput("lat3Level", 32'(level), 32'd1);
        checkBit("lat3Ae", ae, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("popLevel", 32'(level), 32'd0);
        checkBit("popValid", doutValid, 1'b0);

        // Fill to full with no pops
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
            tick();
            checkOutput("fillLevel", 32'(level), 32'(i + 1));
            checkBit("fillAf", af, (i + 1) >= 14);
            checkBit("fillReady", dinReady, (i + 1) != 16);
        end
        applyStimulus(1'b1, 32'h110, 1'b0, 1'b0);
        tick();
        checkOutput("fullHoldLevel", 32'(level), 32'd16);
        checkBit("fullHoldReady", dinReady, 1'b0);
        checkOutput("fullHead", dout, 32'h100);

        // One pop at full: ready returns a cycle later, then the held word enters
        applyStimulus(1'b1, 32'h110, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h110, 1'b0, 1'b0);
        checkOutput("popFullLevel", 32'(level), 32'd15);
        checkBit("popFullReady", dinReady, 1'b1);
        checkOutput("popFullHead", dout, 32'h101);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("refillLevel", 32'(level), 32'd16);
        checkBit("refillReady", dinReady, 1'b0);

        // Drain and verify order 0x101..0x110
        rcv = 0;
        doutReady = 1'b1;
        for (int cyc = 0; cyc < 100 && rcv < 16; cyc++) begin
            if (doutValid) begin
                checkOutput("drainData", dout, 32'h101 + 32'(rcv));
                rcv++;
            end
            tick();
        end
        checkOutput("drainCount", 32'(rcv), 32'd16);
        checkOutput("drainLevel0", 32'(level), 32'd0);
        checkBit("drainAe", ae, 1'b1);
        checkBit("drainReady", dinReady, 1'b1);

        // Streaming 0..999 with random consumer stalls
        sent = 0;
        rcv = 0;
        prevStall = 1'b0;
        prevData = '0;
        for (int cyc = 0; cyc < 20000 && rcv < 1000; cyc++) begin
            if (prevStall) begin
                checkBit("stallValid", doutValid, 1'b1);
                checkOutput("stallData", dout, prevData);
            end
            applyStimulus(sent < 1000, 32'(sent), 1'($urandom_range(0, 1)), 1'b0);
            if (doutValid && doutReady) begin
                checkOutput("streamData", dout, 32'(rcv));
                rcv++;
            end
            if (dinValid && dinReady) sent++;
            prevStall = doutValid && !doutReady;
            prevData = dout;
            tick();
        end
        checkOutput("streamCount", 32'(rcv), 32'd1000);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("streamLevel", 32'(level), 32'd0);

        // Unstalled streaming must deliver a word every cycle
        tp = 0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
            applyStimulus(1'b1, 32'h1000 + 32'(tp), 1'b1, 1'b0);
            if (dinReady) tp++;
            tick();
            seen = doutValid;
        end
        checkBit("tpStart", seen, 1'b1);
        pops = 0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            applyStimulus(1'b1, 32'h1000 + 32'(tp), 1'b1, 1'b0);
            if (doutValid) pops++;
            if (dinReady) tp++;
            tick();
        end
        checkOutput("tpPops", 32'(pops), 32'd50);
        waitEmpty();

        // Flush at level 9 with a concurrent push and pop
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
            tick();
        end
        checkOutput("preFlushLevel", 32'(level), 32'd9);
        checkBit("preFlushAe", ae, 1'b0);
        applyStimulus(1'b1, 32'hBAD, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("flushLevel", 32'(level), 32'd0);
        checkBit("flushValid", doutValid, 1'b0);
        checkBit("flushReady", dinReady, 1'b1);
        checkBit("flushAe", ae, 1'b1);
        tick();
        tick();
        tick();
        checkBit("flushStillEmpty", doutValid, 1'b0);
        checkOutput("flushStillLevel", 32'(level), 32'd0);
        applyStimulus(1'b1, 32'h300, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkBit("postFlushV1", doutValid, 1'b0);
        tick();
        checkBit("postFlushV2", doutValid, 1'b0);
        tick();
        checkBit("postFlushV3", doutValid, 1'b1);
        checkOutput("postFlushData", dout, 32'h300);
        waitEmpty();

        // Asynchronous reset between clock edges
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h400 + 32'(i), 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkBit("preArstValid", doutValid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkBit("arstReady", dinReady, 1'b0);
        checkOutput("arstLevel", 32'(level), 32'd0);
        checkBit("arstValid", doutValid, 1'b0);
        checkOutput("arstData", dout, 32'h0);
        checkBit("arstAe", ae, 1'b1);
        rst_n = 1'b1;
        tick();
        checkBit("postArstReady", dinReady, 1'b1);
        checkBit("postArstValid", doutValid, 1'b0);

        // DEPTH=5: fill, then stream 23 words through wrapping pointers
        for (int i = 0; i < 5; i++) begin
            dinValid5 = 1'b1;
            din5 = 32'h500 + 32'(i);
            tick();
        end
        dinValid5 = 1'b0;
        checkOutput("d5FullLevel", 32'(level5), 32'd5);
        checkBit("d5FullReady", dinReady5, 1'b0);
        checkBit("d5FullAf", af5, 1'b1);
        sent = 5;
        rcv = 0;
        doutReady5 = 1'b1;
        for (int cyc = 0; cyc < 200 && rcv < 23; cyc++) begin
            dinValid5 = (sent < 23);
            din5 = 32'h500 + 32'(sent);
            if (doutValid5) begin
                checkOutput("d5Data", dout5, 32'h500 + 32'(rcv));
                rcv++;
            end
            if (dinValid5 && dinReady5) sent++;
            tick();
        end
        dinValid5 = 1'b0;
        doutReady5 = 1'b0;
        checkOutput("d5Count", 32'(rcv), 32'd23);
        checkOutput("d5Level", 32'(level5), 32'd0);
        checkBit("d5Ae", ae5, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
